// File: rtl/scpu_run_ctrl_pkg.sv
// Shared encodings for the scpu run-control sequencer: FSM states, host commands, halt causes.
// Optional breakpoint logic in the top is enabled by defining SCPU_RUN_CTRL_BREAKPOINT_EN.
package scpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_ST_BOOT   = 2'd0,
    RC_ST_HALTED = 2'd1,
    RC_ST_RUN    = 2'd2,
    RC_ST_STEP   = 2'd3
  } rc_state_e;

  typedef enum logic [1:0] {
    RC_CMD_RUN   = 2'd0,
    RC_CMD_STEP  = 2'd1,
    RC_CMD_HALT  = 2'd2,
    RC_CMD_RESET = 2'd3
  } rc_cmd_e;

  typedef enum logic [1:0] {
    RC_CAUSE_NONE = 2'd0,
    RC_CAUSE_HLT  = 2'd1,
    RC_CAUSE_HOST = 2'd2,
    RC_CAUSE_BKPT = 2'd3
  } rc_cause_e;

  // Width of a counter that must be able to hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scpu_run_ctrl_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/scpu_run_ctrl.sv
// Run-control sequencer for the single-cycle core: owns core reset/clock-enable, takes host commands.
// Define SCPU_RUN_CTRL_BREAKPOINT_EN to add the single PC breakpoint; otherwise bp_* inputs are ignored.
module scpu_run_ctrl
  import scpu_run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             core_halt,
  input  logic [31:0]      core_pc,
  input  logic             bp_set,
  input  logic             bp_clr,
  input  logic [31:0]      bp_addr,
  output logic             core_reset,
  output logic             core_en,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int BOOT_W = cnt_width(RST_CYCLES);

  rc_state_e         state_q;
  rc_cause_e         cause_q;
  rc_cmd_e           cmd;
  logic              cmd_fire;
  logic              bp_hit;
  logic              stop;
  logic              boot_done;
  logic              enter_boot;
  logic [BOOT_W-1:0] boot_cnt;

  assign cmd        = rc_cmd_e'(cmd_op);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign stop       = core_halt | bp_hit;
  assign boot_done  = (boot_cnt == BOOT_W'(RST_CYCLES - 1));
  assign state      = state_q;
  assign halt_cause = cause_q;

  // A RESET command only wins in RUN when nothing of higher priority stops the core.
  assign enter_boot = cmd_fire && (cmd == RC_CMD_RESET) &&
                      ((state_q == RC_ST_HALTED) || ((state_q == RC_ST_RUN) && !stop));

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    core_en   = 1'b0;
    cmd_ready = 1'b0;
    unique case (state_q)
      RC_ST_BOOT:   ;
      RC_ST_HALTED: cmd_ready = 1'b1;
      RC_ST_RUN: begin
        core_en   = !stop;
        cmd_ready = 1'b1;
      end
      RC_ST_STEP:   core_en = !core_halt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    if (reset) begin
      state_q    <= RC_ST_BOOT;
      core_reset <= 1'b1;
      cause_q    <= RC_CAUSE_NONE;
    end else begin
      unique case (state_q)
        RC_ST_BOOT: begin
          if (boot_done) begin
            state_q    <= RC_ST_HALTED;
            core_reset <= 1'b0;
          end
        end
        RC_ST_HALTED: begin
          if (cmd_fire) begin
            unique case (cmd)
              RC_CMD_RUN: begin
                state_q <= RC_ST_RUN;
                cause_q <= RC_CAUSE_NONE;
              end
              RC_CMD_STEP: begin
                state_q <= RC_ST_STEP;
                cause_q <= RC_CAUSE_NONE;
              end
              RC_CMD_RESET: begin
                state_q    <= RC_ST_BOOT;
                core_reset <= 1'b1;
                cause_q    <= RC_CAUSE_NONE;
              end
              RC_CMD_HALT: ;
            endcase
          end
        end
        RC_ST_RUN: begin
          if (stop) begin
            state_q <= RC_ST_HALTED;
            cause_q <= core_halt ? RC_CAUSE_HLT : RC_CAUSE_BKPT;
          end else if (cmd_fire && (cmd == RC_CMD_HALT)) begin
            state_q <= RC_ST_HALTED;
            cause_q <= RC_CAUSE_HOST;
          end else if (cmd_fire && (cmd == RC_CMD_RESET)) begin
            state_q    <= RC_ST_BOOT;
            core_reset <= 1'b1;
            cause_q    <= RC_CAUSE_NONE;
          end
        end
        RC_ST_STEP: begin
          state_q <= RC_ST_HALTED;
          cause_q <= core_halt ? RC_CAUSE_HLT : RC_CAUSE_HOST;
        end
      endcase
    end
  end

  // The boot counter idles at zero outside BOOT, so every entry into BOOT starts a fresh count.
  sat_counter #(.W(BOOT_W)) u_boot_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (state_q != RC_ST_BOOT),
    .en    (state_q == RC_ST_BOOT),
    .count (boot_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (enter_boot),
    .en    (core_en),
    .count (cycle_count)
  );

`ifdef SCPU_RUN_CTRL_BREAKPOINT_EN
  logic [31:0] bp_pc;
  logic        bp_valid;
  logic        skip;

  // skip masks the breakpoint for the first RUN cycle so resuming from it executes that instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bp_pc    <= '0;
      bp_valid <= 1'b0;
      skip     <= 1'b0;
    end else begin
      if (bp_set) begin
        bp_pc    <= bp_addr;
        bp_valid <= 1'b1;
      end else if (bp_clr) begin
        bp_valid <= 1'b0;
      end
      skip <= (state_q == RC_ST_HALTED) && cmd_fire && (cmd == RC_CMD_RUN);
    end
  end

  assign bp_hit = (state_q == RC_ST_RUN) && bp_valid && (core_pc == bp_pc) && !skip;
`else
  logic unused_bp;

  assign unused_bp = ^{bp_set, bp_clr, bp_addr, core_pc};
  assign bp_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_scpu_run_ctrl.sv
// Directed bench for scpu_run_ctrl driving a tiny core model (ROM: 3x ADDI, then HLT at 0x0C).
// Breakpoint scenario expectations follow SCPU_RUN_CTRL_BREAKPOINT_EN.
module tb_scpu_run_ctrl;
  import scpu_run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        core_halt;
  logic [31:0] core_pc;
  logic        bp_set;
  logic        bp_clr;
  logic [31:0] bp_addr;
  logic        core_reset;
  logic        core_en;
  logic [1:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count;

  logic [31:0] pc;
  int          vectors     = 0;
  int          miscompares = 0;
  int          n;

  scpu_run_ctrl #(.RST_CYCLES(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .core_halt   (core_halt),
    .core_pc     (core_pc),
    .bp_set      (bp_set),
    .bp_clr      (bp_clr),
    .bp_addr     (bp_addr),
    .core_reset  (core_reset),
    .core_en     (core_en),
    .state       (state),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Core model: PC advances by 4 per enabled cycle; the word at 0x0C decodes as HLT.
  always @(posedge clk) begin
    if (core_reset) pc <= 32'h0;
    else if (core_en) pc <= pc + 32'h4;
  end
  assign core_pc   = pc;
  assign core_halt = (pc == 32'h0C);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents one command for one cycle; returns at the negedge after the accepting posedge.
  task automatic send(input logic [1:0] op);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts enabled core cycles while in RUN, bounded to 40 cycles.
  task automatic run_count(output int en_cycles);
    en_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (state != RC_ST_RUN) break;
      if (core_en) en_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (state == RC_ST_HALTED) break;
      @(negedge clk);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    bp_set    = 1'b0;
    bp_clr    = 1'b0;
    bp_addr   = 32'h0;

    // Reset state
    #1;
    check("rst_state", state, RC_ST_BOOT);
    check("rst_core_reset", core_reset, 1);
    check("rst_core_en", core_en, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cause", halt_cause, RC_CAUSE_NONE);
    check("rst_count", cycle_count, 0);

    // Boot: core_reset held for exactly 4 posedges
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("boot_core_reset_%0d", i), core_reset, (i < 3) ? 1 : 0);
      check($sformatf("boot_state_%0d", i), state, (i < 3) ? RC_ST_BOOT : RC_ST_HALTED);
    end
    @(negedge clk);
    check("boot_core_en", core_en, 0);
    check("boot_count", cycle_count, 0);
    check("boot_ready", cmd_ready, 1);

    // RUN to HLT at 0x0C
    send(RC_CMD_RUN);
    check("run_state", state, RC_ST_RUN);
    run_count(n);
    check("run_en_cycles", n, 3);
    check("run_state_end", state, RC_ST_HALTED);
    check("run_cause", halt_cause, RC_CAUSE_HLT);
    check("run_count", cycle_count, 3);
    check("run_pc", core_pc, 32'h0C);

    // RUN from HLT with a same-cycle host HALT: HLT wins, no enabled cycle
    send(RC_CMD_RUN);
    check("prio_state_run", state, RC_ST_RUN);
    check("prio_cause_cleared", halt_cause, RC_CAUSE_NONE);
    cmd_valid = 1'b1;
    cmd_op    = RC_CMD_HALT;
    check("prio_core_en", core_en, 0);
    check("prio_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("prio_state", state, RC_ST_HALTED);
    check("prio_cause", halt_cause, RC_CAUSE_HLT);
    check("prio_count", cycle_count, 3);

    // RESET command back to BOOT
    send(RC_CMD_RESET);
    check("rcmd_state", state, RC_ST_BOOT);
    check("rcmd_core_reset", core_reset, 1);
    check("rcmd_count", cycle_count, 0);
    wait_halted(10);
    check("rcmd_halted", state, RC_ST_HALTED);

    // Two STEPs from PC 0
    for (int s = 0; s < 2; s++) begin
      send(RC_CMD_STEP);
      check($sformatf("step%0d_state", s), state, RC_ST_STEP);
      check($sformatf("step%0d_ready", s), cmd_ready, 0);
      check($sformatf("step%0d_en", s), core_en, 1);
      @(negedge clk);
      check($sformatf("step%0d_halted", s), state, RC_ST_HALTED);
      check($sformatf("step%0d_cause", s), halt_cause, RC_CAUSE_HOST);
      check($sformatf("step%0d_en_off", s), core_en, 0);
    end
    check("step_count", cycle_count, 2);
    check("step_pc", core_pc, 32'h08);

    // Breakpoint at 0x08
    send(RC_CMD_RESET);
    wait_halted(10);
    check("bp_boot_halted", state, RC_ST_HALTED);
    @(negedge clk);
    bp_set  = 1'b1;
    bp_addr = 32'h08;
    @(negedge clk);
    bp_set  = 1'b0;
    send(RC_CMD_RUN);
    run_count(n);
`ifdef SCPU_RUN_CTRL_BREAKPOINT_EN
    check("bp_en_cycles", n, 2);
    check("bp_pc", core_pc, 32'h08);
    check("bp_cause", halt_cause, RC_CAUSE_BKPT);
    check("bp_count", cycle_count, 2);
    send(RC_CMD_RUN);
    run_count(n);
    check("bp_resume_en_cycles", n, 1);
    check("bp_resume_pc", core_pc, 32'h0C);
    check("bp_resume_cause", halt_cause, RC_CAUSE_HLT);
    check("bp_resume_count", cycle_count, 3);
`else
    check("nobp_en_cycles", n, 3);
    check("nobp_pc", core_pc, 32'h0C);
    check("nobp_cause", halt_cause, RC_CAUSE_HLT);
    check("nobp_count", cycle_count, 3);
`endif

    // Async reset in the middle of RUN
    send(RC_CMD_RESET);
    wait_halted(10);
    send(RC_CMD_RUN);
    @(negedge clk);
    check("mid_state_run", state, RC_ST_RUN);
    check("mid_en_before", core_en, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_core_en", core_en, 0);
    check("mid_core_reset", core_reset, 1);
    check("mid_state", state, RC_ST_BOOT);
    check("mid_count", cycle_count, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
